// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module : riscv_ctrl_pkg
// Brief  : Shared encodings for the multicycle RV32I controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;

  localparam logic [3:0] C_ALU_ADD = 4'b0000;
  localparam logic [3:0] C_ALU_SUB = 4'b0001;
  localparam logic [3:0] C_ALU_AND = 4'b0010;
  localparam logic [3:0] C_ALU_OR  = 4'b0011;
  localparam logic [3:0] C_ALU_XOR = 4'b0100;
  localparam logic [3:0] C_ALU_SLT = 4'b0101;
  localparam logic [3:0] C_ALU_SLL = 4'b0110;
  localparam logic [3:0] C_ALU_SRL = 4'b0111;
  localparam logic [3:0] C_ALU_SRA = 4'b1000;

  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  localparam logic [1:0] C_SRCA_PC    = 2'b00;
  localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] C_SRCA_RS1   = 2'b10;

  localparam logic [1:0] C_SRCB_RS2  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  localparam logic [1:0] C_IMM_I = 2'b00;
  localparam logic [1:0] C_IMM_S = 2'b01;
  localparam logic [1:0] C_IMM_B = 2'b10;
  localparam logic [1:0] C_IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      C_OP_STORE:  return C_IMM_S;
      C_OP_BRANCH: return C_IMM_B;
      C_OP_JAL:    return C_IMM_J;
      default:     return C_IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module : multicycle_controller_if
// Brief  : Controller <-> datapath bundle; master is the controller side.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7_5;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic [3:0]  ALUCtl;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;

  modport master (
    input  opcode, func3, func7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUCtl, illegal, state, cycle_count, fetch_count
  );

  modport slave (
    output opcode, func3, func7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUCtl, illegal, state, cycle_count, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_decoder.sv
// ============================================================================
// Module : alu_op_decoder
// Brief  : Maps ALUOp/func3/func7_5/opcode[5] to the 4-bit ALU control code.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_func3,
  input  logic       i_func7_5,
  input  logic       i_op5,
  output logic [3:0] o_alu_ctl
);

  always_comb begin
    o_alu_ctl = C_ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_ctl = C_ALU_ADD;
      ALUOP_SUB: o_alu_ctl = C_ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_func3)
          // addi has no SUB form; only R-type (opcode[5]=1) honours func7_5
          3'b000:  o_alu_ctl = (i_op5 && i_func7_5) ? C_ALU_SUB : C_ALU_ADD;
          3'b001:  o_alu_ctl = C_ALU_SLL;
          3'b010:  o_alu_ctl = C_ALU_SLT;
          3'b100:  o_alu_ctl = C_ALU_XOR;
          3'b101:  o_alu_ctl = i_func7_5 ? C_ALU_SRA : C_ALU_SRL;
          3'b110:  o_alu_ctl = C_ALU_OR;
          3'b111:  o_alu_ctl = C_ALU_AND;
          default: o_alu_ctl = C_ALU_ADD;
        endcase
      end
      default: o_alu_ctl = C_ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : FSM sequencing a shared-ALU, shared-memory multicycle RV32I core.
//          Optional perf counters enabled by defining MC_CTRL_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);

  state_t     r_state;
  state_t     w_cur;
  state_t     w_next;
  alu_op_t    w_alu_op;
  logic [3:0] w_alu_ctl;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;

  // Reset overrides the registered state so outputs show FETCH immediately
  assign w_cur = rst ? S_FETCH : r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          C_OP_LOAD, C_OP_STORE: w_next = S_MEMADR;
          C_OP_RTYPE:            w_next = S_EXECUTER;
          C_OP_ITYPE:            w_next = S_EXECUTEI;
          C_OP_BRANCH:           w_next = S_BEQ;
          C_OP_JAL:              w_next = S_JAL;
          default:               w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (bus.opcode == C_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB,
      S_ALUWB,
      S_BEQ:      w_next = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = C_RES_ALUOUT;
    w_alu_src_a  = C_SRCA_PC;
    w_alu_src_b  = C_SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (w_cur)
      S_FETCH: begin
        w_alu_src_b  = C_SRCB_FOUR;
        w_result_src = C_RES_ALURESULT;
        w_ir_write   = bus.mem_ready;
        w_pc_write   = bus.mem_ready;
      end
      // Branch target PC+imm lands in ALUOut ahead of BEQ
      S_DECODE: begin
        w_alu_src_a = C_SRCA_OLDPC;
        w_alu_src_b = C_SRCB_IMM;
      end
      S_MEMADR: begin
        w_alu_src_a = C_SRCA_RS1;
        w_alu_src_b = C_SRCB_IMM;
      end
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = C_RES_DATA;
        w_reg_write  = 1'b1;
      end
      S_EXECUTER: begin
        w_alu_src_a = C_SRCA_RS1;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_alu_src_a = C_SRCA_RS1;
        w_alu_src_b = C_SRCB_IMM;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = C_SRCA_RS1;
        w_alu_op    = ALUOP_SUB;
        w_pc_write  = bus.Zero;
      end
      S_JAL: begin
        w_alu_src_a = C_SRCA_OLDPC;
        w_alu_src_b = C_SRCB_FOUR;
        w_pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .i_alu_op  (w_alu_op),
    .i_func3   (bus.func3),
    .i_func7_5 (bus.func7_5),
    .i_op5     (bus.opcode[5]),
    .o_alu_ctl (w_alu_ctl)
  );

  assign bus.PCWrite   = w_pc_write & ~rst;
  assign bus.IRWrite   = w_ir_write & ~rst;
  assign bus.MemWrite  = w_mem_write & ~rst;
  assign bus.RegWrite  = w_reg_write & ~rst;
  assign bus.AdrSrc    = w_adr_src;
  assign bus.ResultSrc = w_result_src;
  assign bus.ALUSrcA   = w_alu_src_a;
  assign bus.ALUSrcB   = w_alu_src_b;
  assign bus.ImmSrc    = imm_src_of(bus.opcode);
  assign bus.ALUCtl    = w_alu_ctl;
  assign bus.illegal   = (w_cur == S_TRAP);
  assign bus.state     = w_cur;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
      r_fetch_count <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (bus.IRWrite) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign bus.cycle_count = rst ? 32'd0 : r_cycle_count;
  assign bus.fetch_count = rst ? 32'd0 : r_fetch_count;
`else
  assign bus.cycle_count = 32'd0;
  assign bus.fetch_count = 32'd0;
`endif

endmodule

`default_nettype wire
